// File: rtl/uart_rx_os_if.sv
// Consumer-facing signal bundle of the oversampled UART receiver.
// The master side drives the serial line and the clear pulse. The slave side is the receiver.
interface uart_rx_os_if;
   logic       rx;
   logic       rdy_clr;
   logic [7:0] dout;
   logic       rdy;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      output rx,
      output rdy_clr,
      input  dout,
      input  rdy,
      input  frame_err,
      input  overrun,
      input  busy
   );

   modport slave (
      input  rx,
      input  rdy_clr,
      output dout,
      output rdy,
      output frame_err,
      output overrun,
      output busy
   );
endinterface

// File: rtl/uart_rx_os.sv
// 16x-oversampled 8N1 UART receiver with sticky ready, framing-error and overrun flags.
// Every state transition and every line sample is qualified by the oversample tick.
module uart_rx_os #(
   parameter int CLK_HZ   = 50000000,
   parameter int BAUD     = 115200,
   parameter int TICK_DIV = ((CLK_HZ / (BAUD * 16)) < 1) ? 1 : (CLK_HZ / (BAUD * 16))
) (
   input  logic         clk,
   input  logic         rst,
   uart_rx_os_if.slave  bus
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   logic          rx_meta_q, rx_s_q;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;
   logic [2:0]    state_q, state_d;
   logic [3:0]    samp_cnt_q, samp_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    dout_q, dout_d;
   logic          rdy_q, rdy_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;

   assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

   // A byte completing in STOP overrides a simultaneous clear: the new byte wins and overrun stays clear.
   always_comb begin
      state_d     = state_q;
      samp_cnt_d  = samp_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      dout_d      = dout_q;
      rdy_d       = rdy_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;

      if (bus.rdy_clr) begin
         rdy_d       = 1'b0;
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
      end

      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_d    = S_START;
                  samp_cnt_d = 4'd0;
               end
            end
            S_START: begin
               if (samp_cnt_q == 4'd7) begin
                  samp_cnt_d = 4'd0;
                  bit_idx_d  = 3'd0;
                  state_d    = rx_s_q ? S_IDLE : S_DATA;
               end else begin
                  samp_cnt_d = samp_cnt_q + 4'd1;
               end
            end
            S_DATA: begin
               if (samp_cnt_q == 4'd15) begin
                  samp_cnt_d         = 4'd0;
                  shift_d[bit_idx_q] = rx_s_q;
                  if (bit_idx_q == 3'd7) begin
                     state_d = S_STOP;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end else begin
                  samp_cnt_d = samp_cnt_q + 4'd1;
               end
            end
            S_STOP: begin
               if (samp_cnt_q == 4'd15) begin
                  samp_cnt_d = 4'd0;
                  if (rx_s_q) begin
                     dout_d    = shift_q;
                     rdy_d     = 1'b1;
                     overrun_d = bus.rdy_clr ? 1'b0 : (overrun_q | rdy_q);
                     state_d   = S_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = S_WAIT_IDLE;
                  end
               end else begin
                  samp_cnt_d = samp_cnt_q + 4'd1;
               end
            end
            S_WAIT_IDLE: begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         tick_cnt_q  <= '0;
         state_q     <= S_IDLE;
         samp_cnt_q  <= 4'd0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         dout_q      <= 8'h00;
         rdy_q       <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= bus.rx;
         rx_s_q      <= rx_meta_q;
         tick_cnt_q  <= tick_cnt_d;
         state_q     <= state_d;
         samp_cnt_q  <= samp_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         dout_q      <= dout_d;
         rdy_q       <= rdy_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.dout      = dout_q;
   assign bus.rdy       = rdy_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os at 16 clk per bit: a frame-level model schedules each byte's effect
// a fixed number of clocks after its start edge and is compared with the outputs every cycle.
module tb_uart_rx_os;

   localparam int CLK_HZ   = 1843200;
   localparam int BAUD     = 115200;
   localparam int BIT_CLKS = 16;
   // 2 synchroniser clocks + 1 edge detect + 8 start ticks + 8*16 data ticks + 16 stop ticks
   localparam int LATENCY  = 155;

   typedef struct {
      int         when;
      logic [7:0] data;
      bit         ok;
   } frame_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_rx_os_if bus();

   uart_rx_os #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   frame_t     pending[$];
   int         cyc      = 0;
   int         checks   = 0;
   int         errors   = 0;
   bit         checking = 1'b0;
   logic [7:0] expDout  = 8'h00;
   logic       expRdy   = 1'b0;
   logic       expFe    = 1'b0;
   logic       expOv    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Frame-level model: the clear pulse acts first, then a frame scheduled for this edge lands on top.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         expDout <= 8'h00;
         expRdy  <= 1'b0;
         expFe   <= 1'b0;
         expOv   <= 1'b0;
         pending.delete();
      end else begin
         logic [7:0] nd;
         logic       nr, nf, no;
         nd = expDout;
         nr = expRdy;
         nf = expFe;
         no = expOv;
         if (bus.rdy_clr) begin
            nr = 1'b0;
            nf = 1'b0;
            no = 1'b0;
         end
         if (pending.size() > 0 && pending[0].when == cyc + 1) begin
            if (pending[0].ok) begin
               nd = pending[0].data;
               nr = 1'b1;
               no = bus.rdy_clr ? 1'b0 : (expOv | expRdy);
            end else begin
               nf = 1'b1;
            end
            void'(pending.pop_front());
         end
         expDout <= nd;
         expRdy  <= nr;
         expFe   <= nf;
         expOv   <= no;
      end
   end

   always @(negedge clk) begin
      if (checking && !rst) begin
         checks++;
         if ({bus.dout, bus.rdy, bus.frame_err, bus.overrun} !== {expDout, expRdy, expFe, expOv}) begin
            errors++;
            if (errors <= 20)
               $display("[TB] FAIL model cyc=%0d got dout=%02h rdy=%b fe=%b ov=%b expected dout=%02h rdy=%b fe=%b ov=%b",
                        cyc, bus.dout, bus.rdy, bus.frame_err, bus.overrun, expDout, expRdy, expFe, expOv);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic driveBit(input logic v);
      bus.rx = v;
      waitCycles(BIT_CLKS);
   endtask

   task automatic pulseClr();
      bus.rdy_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.rdy_clr = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int gap);
      frame_t f;
      @(posedge clk);
      #1;
      f.when = cyc + LATENCY;
      f.data = data;
      f.ok   = stopBit;
      pending.push_back(f);
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(data[i]);
      driveBit(stopBit);
      bus.rx = 1'b1;
      waitCycles(gap);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      bus.rx      = 1'b1;
      bus.rdy_clr = 1'b0;
      #2 rst = 1'b1;
      waitCycles(2);
      checkOutput("reset_dout", bus.dout, 8'h00);
      checkOutput("reset_rdy", {7'd0, bus.rdy}, 8'h00);
      checkOutput("reset_fe", {7'd0, bus.frame_err}, 8'h00);
      checkOutput("reset_ov", {7'd0, bus.overrun}, 8'h00);
      checkOutput("reset_busy", {7'd0, bus.busy}, 8'h00);
      rst      = 1'b0;
      checking = 1'b1;
      waitCycles(4);

      $display("[TB] ideal frame 0x41");
      applyStimulus(8'h41, 1'b1, 16);
      checkOutput("a_dout", bus.dout, 8'h41);
      checkOutput("a_rdy", {7'd0, bus.rdy}, 8'h01);
      checkOutput("a_fe", {7'd0, bus.frame_err}, 8'h00);
      pulseClr();
      checkOutput("a_clr_rdy", {7'd0, bus.rdy}, 8'h00);

      $display("[TB] overrun 0x30 then 0x46");
      applyStimulus(8'h30, 1'b1, 0);
      applyStimulus(8'h46, 1'b1, 16);
      checkOutput("ov_dout", bus.dout, 8'h46);
      checkOutput("ov_rdy", {7'd0, bus.rdy}, 8'h01);
      checkOutput("ov_flag", {7'd0, bus.overrun}, 8'h01);
      pulseClr();
      checkOutput("ov_clr_rdy", {7'd0, bus.rdy}, 8'h00);
      checkOutput("ov_clr_flag", {7'd0, bus.overrun}, 8'h00);

      $display("[TB] framing error 0x55 then 0x37");
      applyStimulus(8'h55, 1'b0, 16);
      checkOutput("fe_flag", {7'd0, bus.frame_err}, 8'h01);
      checkOutput("fe_rdy", {7'd0, bus.rdy}, 8'h00);
      checkOutput("fe_dout", bus.dout, 8'h46);
      checkOutput("fe_busy", {7'd0, bus.busy}, 8'h00);
      applyStimulus(8'h37, 1'b1, 16);
      checkOutput("fe_next_dout", bus.dout, 8'h37);
      checkOutput("fe_next_rdy", {7'd0, bus.rdy}, 8'h01);
      pulseClr();
      checkOutput("fe_clr_flag", {7'd0, bus.frame_err}, 8'h00);

      $display("[TB] 4 clk glitch");
      @(posedge clk);
      #1;
      bus.rx = 1'b0;
      waitCycles(4);
      bus.rx = 1'b1;
      checkOutput("glitch_busy_hi", {7'd0, bus.busy}, 8'h01);
      waitCycles(20);
      checkOutput("glitch_busy_lo", {7'd0, bus.busy}, 8'h00);
      checkOutput("glitch_rdy", {7'd0, bus.rdy}, 8'h00);
      checkOutput("glitch_fe", {7'd0, bus.frame_err}, 8'h00);

      $display("[TB] reset during bit 3 of 0xA5");
      @(posedge clk);
      #1;
      driveBit(1'b0);
      driveBit(1'b1);
      driveBit(1'b0);
      driveBit(1'b1);
      bus.rx = 1'b0;
      waitCycles(8);
      checkOutput("rst_mid_busy", {7'd0, bus.busy}, 8'h01);
      rst    = 1'b1;
      bus.rx = 1'b1;
      #1;
      checkOutput("rst_mid_dout", bus.dout, 8'h00);
      checkOutput("rst_mid_busy0", {7'd0, bus.busy}, 8'h00);
      waitCycles(2);
      rst = 1'b0;
      waitCycles(4);
      applyStimulus(8'h39, 1'b1, 16);
      checkOutput("after_rst_dout", bus.dout, 8'h39);
      checkOutput("after_rst_rdy", {7'd0, bus.rdy}, 8'h01);

      $display("[TB] clear coinciding with 0x45 completion");
      fork
         applyStimulus(8'h45, 1'b1, 16);
         begin
            @(posedge clk);
            repeat (LATENCY - 1) @(posedge clk);
            #1;
            pulseClr();
         end
      join
      checkOutput("coin_rdy", {7'd0, bus.rdy}, 8'h01);
      checkOutput("coin_dout", bus.dout, 8'h45);
      checkOutput("coin_ov", {7'd0, bus.overrun}, 8'h00);

      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
